// File: rtl/operand_stim_checker.sv
// Self-test stimulus generator and checker for 4-bit two-operand adders (a1, a2 -> q).
// Walks NVEC operand pairs, lets each settle for SETTLE cycles, then scores q against (a1+a2) mod 16.
module operand_stim_checker #(
  parameter int SETTLE = 4,
  parameter int NVEC   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] q,
  output logic [3:0] a1,
  output logic [3:0] a2,
  output logic       busy,
  output logic       done,
  output logic [7:0] pass_cnt,
  output logic [7:0] fail_cnt,
  output logic       err,
  output logic [7:0] first_fail_idx
);

  typedef enum logic [2:0] {ST_IDLE, ST_DRIVE, ST_WAIT, ST_SAMPLE, ST_DONE} state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);
  localparam logic [7:0] LAST_IDX    = 8'(NVEC - 1);

  state_t     state_reg, state_next;
  logic [7:0] idx_reg, settle_reg;
  logic [3:0] a1_reg, a2_reg, exp_reg;
  logic       busy_reg, done_reg, err_reg;
  logic [7:0] pass_reg, fail_reg, ffi_reg;
  logic       accept;
  logic       match;
  logic [3:0] a1_vec, a2_vec, exp_vec;

  // Operand 2 is the vector index rotated by two bit positions.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_a2_rot
      assign a2_vec[gi] = idx_reg[(gi + 2) % 4];
    end
  endgenerate

  assign a1_vec  = idx_reg[3:0];
  assign exp_vec = a1_vec + a2_vec;
  assign match   = (q == exp_reg);

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_DRIVE;
        end
      end
      ST_DRIVE:  state_next = ST_WAIT;
      ST_WAIT:   if (settle_reg == 8'd0) state_next = ST_SAMPLE;
      ST_SAMPLE: state_next = (idx_reg == LAST_IDX) ? ST_DONE : ST_DRIVE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      idx_reg    <= 8'd0;
      settle_reg <= 8'd0;
      a1_reg     <= 4'd0;
      a2_reg     <= 4'd0;
      exp_reg    <= 4'd0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      pass_reg   <= 8'd0;
      fail_reg   <= 8'd0;
      ffi_reg    <= 8'hFF;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            idx_reg  <= 8'd0;
            pass_reg <= 8'd0;
            fail_reg <= 8'd0;
            err_reg  <= 1'b0;
            ffi_reg  <= 8'hFF;
            done_reg <= 1'b0;
            busy_reg <= 1'b1;
          end
        end
        ST_DRIVE: begin
          a1_reg     <= a1_vec;
          a2_reg     <= a2_vec;
          exp_reg    <= exp_vec;
          settle_reg <= SETTLE_LOAD;
        end
        ST_WAIT: begin
          if (settle_reg != 8'd0) settle_reg <= settle_reg - 8'd1;
        end
        ST_SAMPLE: begin
          if (match) begin
            if (pass_reg != 8'hFF) pass_reg <= pass_reg + 8'd1;
          end else begin
            if (fail_reg != 8'hFF) fail_reg <= fail_reg + 8'd1;
            if (!err_reg) begin
              err_reg <= 1'b1;
              ffi_reg <= idx_reg;
            end
          end
          if (idx_reg == LAST_IDX) begin
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
          end else begin
            idx_reg <= idx_reg + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign a1             = a1_reg;
  assign a2             = a2_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign pass_cnt       = pass_reg;
  assign fail_cnt       = fail_reg;
  assign err            = err_reg;
  assign first_fail_idx = ffi_reg;

endmodule

// File: tb/tb_operand_stim_checker.sv
// Bench for operand_stim_checker: two instances (SETTLE=4 and SETTLE=1) driven by a faultable adder model.
module tb_operand_stim_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic start = 1'b0;
  logic sel = 1'b0;          // 0 observes/drives the SETTLE=4 instance, 1 the SETTLE=1 instance
  int   mode = 0;            // 0 correct adder, 1 zero when a1==1, 2 stuck at zero

  logic [3:0] q4, a1_4, a2_4, q1, a1_1, a2_1;
  logic       busy4, done4, err4, busy1, done1, err1;
  logic [7:0] pass4, fail4, ffi4, pass1, fail1, ffi1;
  logic       start4, start1;

  assign start4 = start & ~sel;
  assign start1 = start & sel;

  function automatic logic [3:0] adder_model(input logic [3:0] x, input logic [3:0] y, input int m);
    logic [3:0] s;
    s = x + y;
    if (m == 2) s = 4'd0;
    if (m == 1 && x == 4'd1) s = 4'd0;
    return s;
  endfunction

  assign q4 = adder_model(a1_4, a2_4, mode);
  assign q1 = adder_model(a1_1, a2_1, mode);

  operand_stim_checker #(.SETTLE(4), .NVEC(16)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .q(q4), .a1(a1_4), .a2(a2_4),
    .busy(busy4), .done(done4), .pass_cnt(pass4), .fail_cnt(fail4),
    .err(err4), .first_fail_idx(ffi4)
  );

  operand_stim_checker #(.SETTLE(1), .NVEC(16)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .q(q1), .a1(a1_1), .a2(a2_1),
    .busy(busy1), .done(done1), .pass_cnt(pass1), .fail_cnt(fail1),
    .err(err1), .first_fail_idx(ffi1)
  );

  logic [3:0] o_a1, o_a2;
  logic       o_busy, o_done, o_err;
  logic [7:0] o_pass, o_fail, o_ffi;
  assign o_a1   = sel ? a1_1  : a1_4;
  assign o_a2   = sel ? a2_1  : a2_4;
  assign o_busy = sel ? busy1 : busy4;
  assign o_done = sel ? done1 : done4;
  assign o_err  = sel ? err1  : err4;
  assign o_pass = sel ? pass1 : pass4;
  assign o_fail = sel ? fail1 : fail4;
  assign o_ffi  = sel ? ffi1  : ffi4;

  typedef struct packed {
    logic [7:0] pass;
    logic [7:0] fail;
    logic       err;
    logic [7:0] ffi;
  } result_t;

  logic [7:0] op_q[$];
  result_t    res_q[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard producer: expected operand pairs and the final run result for a given fault mode.
  task automatic push_run(input int m);
    result_t r;
    logic [3:0] x, y, s;
    r.pass = 8'd0; r.fail = 8'd0; r.err = 1'b0; r.ffi = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      x = 4'(i);
      y = {x[1:0], x[3:2]};
      s = 4'((int'(x) + int'(y)) % 16);
      op_q.push_back({x, y});
      if (adder_model(x, y, m) == s) r.pass++;
      else begin
        r.fail++;
        if (!r.err) begin r.err = 1'b1; r.ffi = 8'(i); end
      end
    end
    res_q.push_back(r);
  endtask

  // Pulse start, follow the run cycle by cycle, and optionally pulse start again at run cycle extra_at.
  task automatic do_run(input int settle, input int extra_at);
    int total, busy_cycles;
    logic [7:0] op;
    result_t r;
    total = 16 * (settle + 2);
    busy_cycles = 0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("done_cleared", o_done, 1'b0);
    for (int c = 0; c < total; c++) begin
      if (o_busy) busy_cycles++;
      if (c >= 1 && ((c - 1) % (settle + 2)) == 0) begin
        op = op_q.pop_front();
        chk($sformatf("operands_v%0d", (c - 1) / (settle + 2)), {o_a1, o_a2}, op);
      end
      if (c == extra_at) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    r = res_q.pop_front();
    chk("busy_cycles", busy_cycles, total);
    chk("busy_end", o_busy, 1'b0);
    chk("done_end", o_done, 1'b1);
    chk("pass_cnt", o_pass, r.pass);
    chk("fail_cnt", o_fail, r.fail);
    chk("err", o_err, r.err);
    chk("first_fail_idx", o_ffi, r.ffi);
    $display("[TB] run settle=%0d mode=%0d pass=%0d fail=%0d err=%0b ffi=%0h",
             settle, mode, o_pass, o_fail, o_err, o_ffi);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_a1"}, o_a1, 4'd0);
    chk({tag, "_a2"}, o_a2, 4'd0);
    chk({tag, "_busy"}, o_busy, 1'b0);
    chk({tag, "_done"}, o_done, 1'b0);
    chk({tag, "_pass"}, o_pass, 8'd0);
    chk({tag, "_fail"}, o_fail, 8'd0);
    chk({tag, "_err"}, o_err, 1'b0);
    chk({tag, "_ffi"}, o_ffi, 8'hFF);
  endtask

  initial begin
    // Reset, with start asserted in the same cycle: reset must win.
    reset = 1'b1; start = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; start = 1'b0;
    chk_reset_state("reset");
    @(posedge clk); #1;
    chk("start_with_reset_idle", o_busy, 1'b0);

    // Clean run, SETTLE=4.
    mode = 0; push_run(0); do_run(4, -1);

    // Single fault at a1==1.
    mode = 1; push_run(1); do_run(4, -1);

    // q stuck at zero.
    mode = 2; push_run(2); do_run(4, -1);

    // Reset during WAIT of vector 7: DRIVE of v7 is run cycle 1+7*6-1, so check after its register edge.
    mode = 0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (1 + 7 * 6 + 1) @(posedge clk);
    #1;
    chk("pre_reset_v7_a1", o_a1, 4'd7);
    chk("pre_reset_busy", o_busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk_reset_state("midrun_reset");
    push_run(0); do_run(4, -1);

    // SETTLE=1 instance: dirty run, then a clean restart with an ignored start at run cycle 20.
    sel = 1'b1;
    mode = 2; push_run(2); do_run(1, -1);
    mode = 0; push_run(0); do_run(1, 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/operand_stim_checker.md
Name: operand_stim_checker

Overview:
Hardware counterpart of the bench-side stimulus/monitor loop for the 4-bit two-operand combinational blocks (a1, a2 -> q). It drives a deterministic sequence of operand pairs onto a1/a2 and waits a programmable settle time. It then samples q, compares it against the expected sum (a1 + a2) mod 16, and keeps pass/fail statistics. It sits beside a DUT instance `top` in on-chip self-test and in simulation regressions.

Parameters:
SETTLE, 4, number of clk cycles operands are held before q is sampled (legal range 1..255).
NVEC, 16, number of vectors per run (legal range 1..255).

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  single-cycle pulse; begins a run when idle or done.
q  input  4  DUT result, combinational function of a1/a2.
a1  output  4  operand 1 driven to the DUT.
a2  output  4  operand 2 driven to the DUT.
busy  output  1  high from the cycle after start is accepted until the run ends.
done  output  1  high after a run completes; held until the next start or reset.
pass_cnt  output  8  number of vectors where q matched the expected value.
fail_cnt  output  8  number of vectors where q mismatched.
err  output  1  sticky; set on the first mismatch of a run.
first_fail_idx  output  8  index of the first mismatching vector; 8'hFF if there was none.

Behaviour:
- Reset: synchronous, active-high, takes priority over everything, including mid-run. After reset: a1=0, a2=0, busy=0, done=0, pass_cnt=0, fail_cnt=0, err=0, first_fail_idx=8'hFF, FSM=IDLE, idx=0, settle counter=0.
- Vector i (idx counter, 8 bits): a1=i[3:0], a2={i[1:0],i[3:2]}. Expected = (a1+a2) mod 16, using 4-bit wrap with the carry discarded.
- FSM states: IDLE, DRIVE, WAIT, SAMPLE, DONE.
  - IDLE/DONE + start=1: clear pass_cnt, fail_cnt, err, first_fail_idx (to 8'hFF), idx=0, done=0. Go to DRIVE.
  - DRIVE: register a1/a2 from idx, load settle counter with SETTLE-1, busy=1. Go to WAIT.
  - WAIT: decrement the counter. Go to SAMPLE when the counter reaches 0. With SETTLE=1, WAIT lasts exactly one cycle.
  - SAMPLE: compare q with the registered expected value.
    - Match: pass_cnt+1.
    - Mismatch: fail_cnt+1. If err=0 before this sample, set err=1 and first_fail_idx=idx.
    - Then if idx==NVEC-1, go to DONE. Otherwise idx+1 and go to DRIVE.
  - DONE: busy=0, done=1. a1/a2 hold the last vector.
- start while busy: ignored, with no restart and no counter disturbance.
- Timing: operands change only on the DRIVE->WAIT edge and stay stable for SETTLE+1 cycles through SAMPLE. Each vector takes SETTLE+2 cycles. A run takes NVEC*(SETTLE+2) cycles from DRIVE entry to DONE entry.
- Counters: 8 bits, saturating at 255. They cannot overflow within legal NVEC.
- Sampling: q is sampled only in SAMPLE; glitches on q in DRIVE/WAIT are not visible.
- Start in the same cycle as reset: reset wins and the FSM stays in IDLE.

Test Plan:
1. Reset, then start with q driven by a correct adder, SETTLE=4, NVEC=16 -> busy for 96 cycles; done=1; pass_cnt=16, fail_cnt=0, err=0, first_fail_idx=8'hFF.
2. Vector check at idx=5 -> a1=4'b0101, a2=4'b0101, expected 4'b1010. Also idx=15 -> a1=4'b1111, a2=4'b1111, expected 4'b1110 (wrap).
3. Adder with q forced to 0 when a1==4'd1 -> idx 1 fails only. pass_cnt=15, fail_cnt=1, err=1, first_fail_idx=1.
4. q stuck at 4'b0000 -> only idx 0 passes. fail_cnt=15, first_fail_idx=1, err=1.
5. Assert reset for 1 cycle during WAIT of idx 7 -> next cycle all outputs at reset values. A fresh start then gives a full clean run with pass_cnt=16.
6. Pulse start at run cycle 20 while busy -> no effect. A second start after done restarts cleanly and clears the counters. With SETTLE=1, each vector takes 3 cycles.
